// File: rtl/rf80386_prefetch_queue.sv
// rf80386_prefetch_queue
//   Instruction prefetch byte queue. Aligned code lines from the I-cache are
//   written into a circular byte buffer. The decoder sees a window of up to
//   OUTB head bytes and consumes a variable number of them each cycle.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   flush_i      drop queue contents, restart fetch at flush_adr_i
//   flush_adr_i  linear restart address
//   fetch_req_o  request for the line at fetch_adr_o
//   fetch_adr_o  LINEW-aligned line address
//   line_vld_i   line_i holds the line for fetch_adr_o
//   line_i       code line, byte k at bits [8k+7:8k]
//   win_o        decoder window, byte 0 is the byte at pc_o
//   avail_o      valid bytes in win_o (the rest read as 8'h90)
//   take_i       bytes consumed this cycle
//   pc_o         linear address of the head byte
//   count_o      bytes currently held
module rf80386_prefetch_queue #(
  parameter int          LINEW    = 16,
  parameter int          DEPTH    = 32,
  parameter int          OUTB     = 8,
  parameter logic [31:0] RESET_PC = 32'hFFFF_FFF0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [31:0]                flush_adr_i,
  output logic                       fetch_req_o,
  output logic [31:0]                fetch_adr_o,
  input  logic                       line_vld_i,
  input  logic [LINEW*8-1:0]         line_i,
  output logic [OUTB*8-1:0]          win_o,
  output logic [$clog2(OUTB+1)-1:0]  avail_o,
  input  logic [$clog2(OUTB+1)-1:0]  take_i,
  output logic [31:0]                pc_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LINEW);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(OUTB + 1);

  logic [7:0]    ram_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   pc_r;
  logic [31:0]   fadr_r;

  logic [LW-1:0] off_s;
  logic [CW-1:0] n_in_s;
  logic [CW-1:0] space_s;
  logic [CW-1:0] take_ext_s;
  logic [CW-1:0] n_take_s;
  logic [CW-1:0] n_add_s;
  logic          accept_s;
  logic [TW-1:0] avail_s;

  // Fetch request, accept qualification and consume clamp from registered state.
  always_comb begin
    off_s       = fadr_r[LW-1:0];
    n_in_s      = CW'(LINEW) - CW'(off_s);
    space_s     = CW'(DEPTH) - count_r;
    // Space is judged on the pre-consume count, so count can never pass DEPTH.
    fetch_req_o = !rst_i && !flush_i && (space_s >= CW'(LINEW));
    fetch_adr_o = {fadr_r[31:LW], {LW{1'b0}}};
    accept_s    = fetch_req_o && line_vld_i;
    take_ext_s  = CW'(take_i);
    // Over-take is a decoder protocol error; clamping keeps pointers coherent.
    if (take_ext_s > count_r) begin
      n_take_s = count_r;
    end else begin
      n_take_s = take_ext_s;
    end
    if (accept_s) begin
      n_add_s = n_in_s;
    end else begin
      n_add_s = {CW{1'b0}};
    end
  end

  // Queue control state: pointers, byte count, head pc and next fetch address.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      pc_r     <= RESET_PC;
      fadr_r   <= RESET_PC;
    end else if (flush_i) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      pc_r     <= flush_adr_i;
      fadr_r   <= flush_adr_i;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + n_in_s[AW-1:0];
        fadr_r   <= fetch_adr_o + 32'(LINEW);
      end
      rd_ptr_r <= rd_ptr_r + n_take_s[AW-1:0];
      pc_r     <= pc_r + 32'(n_take_s);
      count_r  <= count_r + n_add_s - n_take_s;
    end
  end

  // Byte storage; only bytes at or above the line offset are queued.
  always_ff @(posedge clk_i) begin
    if (accept_s) begin
      for (int k = 0; k < LINEW; k++) begin
        if (k >= int'(off_s)) begin
          ram_r[wr_ptr_r + AW'(k) - AW'(off_s)] <= line_i[8*k +: 8];
        end
      end
    end
  end

  // Decoder window: head bytes, NOP-filled beyond the valid count.
  always_comb begin
    if (count_r < CW'(OUTB)) begin
      avail_s = TW'(count_r);
    end else begin
      avail_s = TW'(OUTB);
    end
    win_o = {OUTB{8'h90}};
    for (int k = 0; k < OUTB; k++) begin
      if (k < int'(avail_s)) begin
        win_o[8*k +: 8] = ram_r[rd_ptr_r + AW'(k)];
      end else begin
        win_o[8*k +: 8] = 8'h90;
      end
    end
  end

  assign avail_o = avail_s;
  assign pc_o    = pc_r;
  assign count_o = count_r;

endmodule

// File: tb/tb_rf80386_prefetch_queue.sv
// Directed bench for rf80386_prefetch_queue with default parameters
// (LINEW=16, DEPTH=32, OUTB=8, RESET_PC=FFFF_FFF0). Expected values are
// hand-computed constants.
module tb_rf80386_prefetch_queue;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         flush_i = 1'b0;
  logic [31:0]  flush_adr_i = 32'h0;
  logic         fetch_req_o;
  logic [31:0]  fetch_adr_o;
  logic         line_vld_i = 1'b0;
  logic [127:0] line_i = 128'h0;
  logic [63:0]  win_o;
  logic [3:0]   avail_o;
  logic [3:0]   take_i = 4'd0;
  logic [31:0]  pc_o;
  logic [5:0]   count_o;

  int n_checks = 0;
  int n_err    = 0;

  rf80386_prefetch_queue dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .flush_adr_i (flush_adr_i),
    .fetch_req_o (fetch_req_o),
    .fetch_adr_o (fetch_adr_o),
    .line_vld_i  (line_vld_i),
    .line_i      (line_i),
    .win_o       (win_o),
    .avail_o     (avail_o),
    .take_i      (take_i),
    .pc_o        (pc_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_line(input logic [7:0] base);
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = base + 8'(k);
    return l;
  endfunction

  // One clock: inputs applied before the edge, then cleared, sampled 2ns after.
  task automatic tick();
    @(posedge clk_i);
    #1;
    line_vld_i = 1'b0;
    take_i     = 4'd0;
    flush_i    = 1'b0;
    #1;
  endtask

  initial begin
    // Reset held
    tick();
    tick();
    chk("rst_req",   64'(fetch_req_o), 64'd0);
    chk("rst_avail", 64'(avail_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_pc",    64'(pc_o), 64'hFFFF_FFF0);
    chk("rst_win",   win_o, 64'h9090_9090_9090_9090);

    rst_i = 1'b0;
    #1;
    chk("rel_req",  64'(fetch_req_o), 64'd1);
    chk("rel_adr",  64'(fetch_adr_o), 64'hFFFF_FFF0);

    // First line 00..0F, fetch address wraps to 0
    line_vld_i = 1'b1; line_i = mk_line(8'h00);
    tick();
    chk("l1_count", 64'(count_o), 64'd16);
    chk("l1_avail", 64'(avail_o), 64'd8);
    chk("l1_win",   win_o, 64'h0706_0504_0302_0100);
    chk("l1_adr",   64'(fetch_adr_o), 64'h0000_0000);
    chk("l1_pc",    64'(pc_o), 64'hFFFF_FFF0);

    // Flush to unaligned 1003, partial first line
    flush_i = 1'b1; flush_adr_i = 32'h0000_1003;
    tick();
    chk("fl_count", 64'(count_o), 64'd0);
    chk("fl_avail", 64'(avail_o), 64'd0);
    chk("fl_req",   64'(fetch_req_o), 64'd1);
    chk("fl_adr",   64'(fetch_adr_o), 64'h0000_1000);
    chk("fl_pc",    64'(pc_o), 64'h0000_1003);
    line_vld_i = 1'b1; line_i = mk_line(8'h00);
    tick();
    chk("part_count", 64'(count_o), 64'd13);
    chk("part_win",   win_o, 64'h0A09_0807_0605_0403);
    chk("part_adr",   64'(fetch_adr_o), 64'h0000_1010);

    // Fill to full, then drain
    flush_i = 1'b1; flush_adr_i = 32'h0000_2000;
    tick();
    line_vld_i = 1'b1; line_i = mk_line(8'h20);
    tick();
    chk("fa_count", 64'(count_o), 64'd16);
    line_vld_i = 1'b1; line_i = mk_line(8'h30);
    tick();
    chk("full_count", 64'(count_o), 64'd32);
    chk("full_req",   64'(fetch_req_o), 64'd0);
    chk("full_adr",   64'(fetch_adr_o), 64'h0000_2020);
    // line_vld_i without request is ignored
    line_vld_i = 1'b1; line_i = mk_line(8'hE0); take_i = 4'd8;
    tick();
    chk("t1_count", 64'(count_o), 64'd24);
    chk("t1_req",   64'(fetch_req_o), 64'd0);
    chk("t1_pc",    64'(pc_o), 64'h0000_2008);
    take_i = 4'd8;
    tick();
    chk("t2_count", 64'(count_o), 64'd16);
    chk("t2_req",   64'(fetch_req_o), 64'd1);
    chk("t2_win",   win_o, 64'h3736_3534_3332_3130);
    // Accept with take, then check buffer wrap
    line_vld_i = 1'b1; line_i = mk_line(8'h40); take_i = 4'd8;
    tick();
    chk("t3_count", 64'(count_o), 64'd24);
    chk("t3_win",   win_o, 64'h3F3E_3D3C_3B3A_3938);
    take_i = 4'd8;
    tick();
    chk("wrap_pc",  64'(pc_o), 64'h0000_2020);
    chk("wrap_win", win_o, 64'h4746_4544_4342_4140);

    // count=10, accept and take 5 same cycle
    flush_i = 1'b1; flush_adr_i = 32'h0000_3000;
    tick();
    line_vld_i = 1'b1; line_i = mk_line(8'h50);
    tick();
    take_i = 4'd6;
    tick();
    chk("c10_count", 64'(count_o), 64'd10);
    line_vld_i = 1'b1; line_i = mk_line(8'h60); take_i = 4'd5;
    tick();
    chk("sim_count", 64'(count_o), 64'd21);
    chk("sim_pc",    64'(pc_o), 64'h0000_300B);
    chk("sim_win",   win_o, 64'h6261_605F_5E5D_5C5B);

    // Drain to 3, then over-take clamps
    take_i = 4'd8; tick();
    take_i = 4'd8; tick();
    take_i = 4'd2; tick();
    chk("c3_count", 64'(count_o), 64'd3);
    chk("c3_avail", 64'(avail_o), 64'd3);
    chk("c3_win",   win_o, 64'h9090_9090_906F_6E6D);
    take_i = 4'd8;
    tick();
    chk("clamp_count", 64'(count_o), 64'd0);
    chk("clamp_pc",    64'(pc_o), 64'h0000_3020);
    chk("clamp_avail", 64'(avail_o), 64'd0);
    chk("clamp_win",   win_o, 64'h9090_9090_9090_9090);

    // Flush wins over same-cycle line and take
    line_vld_i = 1'b1; line_i = mk_line(8'h70);
    tick();
    chk("pre_count", 64'(count_o), 64'd16);
    flush_i = 1'b1; flush_adr_i = 32'h0000_4005; line_vld_i = 1'b1;
    line_i = mk_line(8'h80); take_i = 4'd4;
    tick();
    chk("fp_count", 64'(count_o), 64'd0);
    chk("fp_pc",    64'(pc_o), 64'h0000_4005);
    chk("fp_adr",   64'(fetch_adr_o), 64'h0000_4000);
    line_vld_i = 1'b1; line_i = mk_line(8'h80);
    tick();
    chk("fp_line", 64'(count_o), 64'd11);

    // Asynchronous reset mid-cycle
    #1;
    rst_i = 1'b1;
    #1;
    chk("ar_count", 64'(count_o), 64'd0);
    chk("ar_pc",    64'(pc_o), 64'hFFFF_FFF0);
    chk("ar_req",   64'(fetch_req_o), 64'd0);
    chk("ar_avail", 64'(avail_o), 64'd0);
    chk("ar_win",   win_o, 64'h9090_9090_9090_9090);
    rst_i = 1'b0;
    #1;
    chk("ar_adr", 64'(fetch_adr_o), 64'hFFFF_FFF0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
